// File: rtl/debounce_sampler_if.sv
// Signal bundle between the debounce sampler and its user: the divided tick,
// the raw noisy input, and the debounced level with its edge pulses.
interface debounce_sampler_if;
    logic tick_in;
    logic raw_in;
    logic clean_out;
    logic rise_pulse;
    logic fall_pulse;

    modport master (
        output tick_in,
        output raw_in,
        input  clean_out,
        input  rise_pulse,
        input  fall_pulse
    );

    modport slave (
        input  tick_in,
        input  raw_in,
        output clean_out,
        output rise_pulse,
        output fall_pulse
    );
endinterface

// File: rtl/debounce_sampler.sv
// Debounces a noisy asynchronous input, sampling it once per rising edge of a
// divided tick; produces a clean level plus single-cycle press/release pulses.
module debounce_sampler #(
    parameter int STABLE_SAMPLES = 4,
    parameter int CNT_BITS       = 3
) (
    input logic clk,
    input logic rst,
    debounce_sampler_if.slave bus
);

    typedef enum logic {
        STABLE,
        CHANGING
    } state_t;

    localparam logic [CNT_BITS-1:0] LAST_COUNT = CNT_BITS'(STABLE_SAMPLES - 1);
    localparam logic [CNT_BITS-1:0] ONE_COUNT  = CNT_BITS'(1);

    logic tick_s1;
    logic tick_s2;
    logic tick_prev;
    logic raw_s1;
    logic raw_s2;
    logic sample_en;

    state_t              state;
    state_t              state_next;
    logic [CNT_BITS-1:0] count;
    logic [CNT_BITS-1:0] count_next;
    logic                clean;
    logic                clean_next;
    logic                rise;
    logic                rise_next;
    logic                fall;
    logic                fall_next;

    // Two-flop synchronisers for both asynchronous inputs, plus edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_s1   <= 1'b0;
            tick_s2   <= 1'b0;
            tick_prev <= 1'b0;
            raw_s1    <= 1'b0;
            raw_s2    <= 1'b0;
        end else begin
            tick_s1   <= bus.tick_in;
            tick_s2   <= tick_s1;
            tick_prev <= tick_s2;
            raw_s1    <= bus.raw_in;
            raw_s2    <= raw_s1;
        end
    end

    assign sample_en = tick_s2 & ~tick_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STABLE;
            count <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            clean <= clean_next;
            rise  <= rise_next;
            fall  <= fall_next;
        end
    end

    // Pulses are computed alongside the flip so they land with the new level
    always_comb begin
        state_next = state;
        count_next = count;
        clean_next = clean;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        if (sample_en) begin
            case (state)
                STABLE: begin
                    if (raw_s2 == clean) begin
                        count_next = '0;
                    end else if (STABLE_SAMPLES == 1) begin
                        clean_next = raw_s2;
                        rise_next  = raw_s2;
                        fall_next  = ~raw_s2;
                        count_next = '0;
                    end else begin
                        state_next = CHANGING;
                        count_next = ONE_COUNT;
                    end
                end
                CHANGING: begin
                    if (raw_s2 == clean) begin
                        state_next = STABLE;
                        count_next = '0;
                    end else if (count == LAST_COUNT) begin
                        clean_next = raw_s2;
                        rise_next  = raw_s2;
                        fall_next  = ~raw_s2;
                        state_next = STABLE;
                        count_next = '0;
                    end else begin
                        count_next = count + ONE_COUNT;
                    end
                end
                default: begin
                    state_next = STABLE;
                    count_next = '0;
                end
            endcase
        end
    end

    assign bus.clean_out  = clean;
    assign bus.rise_pulse = rise;
    assign bus.fall_pulse = fall;

endmodule

// File: doc/debounce_sampler.md
Name: debounce_sampler

Overview:
- Consumes the divided slow clock from the clock divider as a sampling strobe.
- Debounces one noisy asynchronous input, such as a push-button or switch, and produces a clean level plus single-cycle press and release pulses.
- Runs entirely in the fast clk domain. Both the divided clock and the raw input are synchronised internally, and each rising edge of the divided clock is converted into a one-cycle sample enable.

Parameters:
- STABLE_SAMPLES, 4: number of consecutive sample strobes that must all disagree with clean_out before clean_out flips. Legal range is 1 to 2^CNT_BITS.
- CNT_BITS, 3: width of the internal agreement counter. Must satisfy 2^CNT_BITS >= STABLE_SAMPLES.

Ports:
- clk  input  1  fast system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- tick_in  input  1  divided clock level from the clock divider; asynchronous to clk for synchronisation purposes.
- raw_in  input  1  noisy asynchronous input.
- clean_out  output  1  debounced level, registered.
- rise_pulse  output  1  one-clk pulse when clean_out goes 0->1.
- fall_pulse  output  1  one-clk pulse when clean_out goes 1->0.

Behaviour:
- Reset:
  - When rst=1 at a posedge, every flop clears on that edge: both synchroniser chains, tick_prev, count, state=STABLE, clean_out=0, rise_pulse=0, fall_pulse=0.
  - Reset mid-operation aborts any pending change; no pulse is emitted.
- Synchronisers:
  - Two flops each: tick_s1->tick_s2 and raw_s1->raw_s2.
  - tick_prev <= tick_s2.
- Sample strobe:
  - Internal combinational sample_en = tick_s2 & ~tick_prev.
  - It is exactly one clk cycle per rising edge of tick_in, 3 clk edges after tick_in rises.
  - No strobe is generated on a falling edge of tick_in.
  - With tick_in held constant, no sampling occurs and all outputs hold.
- FSM, with updates only in cycles where sample_en=1 (otherwise state, count, clean_out hold):
  - STABLE, raw_s2 == clean_out: stay; count=0.
  - STABLE, raw_s2 != clean_out: if STABLE_SAMPLES==1, flip clean_out, pulse, and stay STABLE with count=0. Otherwise go to CHANGING with count=1.
  - CHANGING, raw_s2 == clean_out: bounce detected; return to STABLE with count=0 and no output change.
  - CHANGING, raw_s2 != clean_out, count == STABLE_SAMPLES-1: flip clean_out, pulse, go to STABLE with count=0.
  - CHANGING, raw_s2 != clean_out, otherwise: count <= count+1.
- Pulses:
  - rise_pulse and fall_pulse are registered and asserted in the same cycle that clean_out takes its new value.
  - Each is high for exactly one clk; they are never both high.
  - Both are forced to 0 in every cycle without a flip.
- Latency: clean_out changes on the clk edge of the STABLE_SAMPLES-th consecutive disagreeing sample_en.
- Counter: never exceeds STABLE_SAMPLES-1 and never wraps.
- Simultaneous events:
  - raw_in changing in the same cycle as a tick edge is resolved by the synchronisers. The sample uses whatever raw_s2 holds in the sample_en cycle.
  - rst wins over sample_en.

Test Plan:
- Reset and idle:
  - Stimulus: rst=1 for 3 cycles, then tick_in toggling every 16 clk (period 32), raw_in=0.
  - Required response: clean_out, rise_pulse and fall_pulse stay 0 for 20 tick periods; sample_en is seen once per 32 clk.
- Clean press (STABLE_SAMPLES=4):
  - Stimulus: raw_in 0->1 and held.
  - Required response: clean_out rises on the 4th sample_en after raw_s2=1; rise_pulse is high exactly that one cycle; fall_pulse stays 0.
- Bounce rejection:
  - Stimulus: raw_in=1 for 3 samples, 0 for 1 sample, then 1 for 3 samples.
  - Required response: clean_out stays 0 and no pulses occur. Holding 1 for a 4th further sample then gives clean_out=1 and one rise_pulse.
- Release:
  - Stimulus: from clean_out=1, raw_in 1->0 held.
  - Required response: after 4 samples, clean_out=0 and a single fall_pulse; rise_pulse stays 0.
- Reset mid-pending:
  - Stimulus: raw_in=1 held for 2 samples (count=2), then rst for 1 clk, then raw_in kept 1.
  - Required response: outputs stay 0 through reset, and clean_out rises only after 4 fresh samples post-reset.
- Edge cases:
  - STABLE_SAMPLES=1: clean_out follows raw_s2 at every sample_en, with one pulse per change.
  - tick_in held high: no sampling regardless of raw_in activity.
